// File: rtl/mult_seq_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
// Defaults track the codebase data width; STEP selects bits retired per cycle.
package mult_seq_pkg;

  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned MULT_WIDTH_DEF = DATA_WIDTH;

  localparam int unsigned STEP_1 = 1;
  localparam int unsigned STEP_2 = 2;
  localparam int unsigned STEP_4 = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } mult_state_t;

  // Width of a counter that must reach n-1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic bit step_is_legal(input int unsigned s);
    return (s == STEP_1) || (s == STEP_2) || (s == STEP_4);
  endfunction

endpackage

// File: rtl/mult_seq_step.sv
// One STEP-bit partial-product slice: accumulator high half plus |A| times the
// current multiplier chunk, returned with its carry bits.
module mult_seq_step
  import mult_seq_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH_DEF,
  parameter int unsigned STEP  = STEP_1
) (
  input  logic [WIDTH-1:0]      i_acc_hi,
  input  logic [WIDTH-1:0]      i_mcand,
  input  logic [STEP-1:0]       i_chunk,
  output logic [WIDTH+STEP-1:0] o_sum_c
);

  localparam int unsigned SW = WIDTH + STEP;

  always_comb begin
    o_sum_c = SW'(i_acc_hi);
    for (int i = 0; i < int'(STEP); i++) begin
      if (i_chunk[i]) begin
        o_sum_c = o_sum_c + (SW'(i_mcand) << i);
      end
    end
  end

endmodule

// File: rtl/mult_seq_param.sv
// Multi-cycle shift-add multiplier with start/done handshake and signed mode.
// Define MULT_SEQ_OVF_EN to add the registered OVF output.
module mult_seq_param
  import mult_seq_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH_DEF,
  parameter int unsigned STEP  = STEP_1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             SIGNED,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             READY,
  output logic             DONE,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
`ifdef MULT_SEQ_OVF_EN
  ,
  output logic             OVF
`endif
);

  localparam int unsigned N     = WIDTH / STEP;
  localparam int unsigned AW    = 2 * WIDTH;
  localparam int unsigned SW    = WIDTH + STEP;
  localparam int unsigned CNT_W = cnt_width(N);

  mult_state_t      r_state,  w_state_nxt;
  logic             r_ready,  w_ready_nxt;
  logic             r_done,   w_done_nxt;
  logic             r_sign_a, w_sign_a_nxt;
  logic             r_sign_b, w_sign_b_nxt;
  logic [WIDTH-1:0] r_mag_a,  w_mag_a_nxt;
  logic [WIDTH-1:0] r_mplr,   w_mplr_nxt;
  logic [AW-1:0]    r_acc,    w_acc_nxt;
  logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;
  logic [WIDTH-1:0] r_hi,     w_hi_nxt;
  logic [WIDTH-1:0] r_lo,     w_lo_nxt;
  logic [SW-1:0]    w_sum;
  logic [AW-1:0]    w_prod;
`ifdef MULT_SEQ_OVF_EN
  logic             r_signed, w_signed_nxt;
  logic             r_ovf,    w_ovf_nxt;
`endif

  mult_seq_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .i_acc_hi (r_acc[AW-1:WIDTH]),
    .i_mcand  (r_mag_a),
    .i_chunk  (r_mplr[STEP-1:0]),
    .o_sum_c  (w_sum)
  );

  // Next-state and datapath updates.
  always_comb begin
    w_state_nxt  = r_state;
    w_done_nxt   = 1'b0;
    w_sign_a_nxt = r_sign_a;
    w_sign_b_nxt = r_sign_b;
    w_mag_a_nxt  = r_mag_a;
    w_mplr_nxt   = r_mplr;
    w_acc_nxt    = r_acc;
    w_cnt_nxt    = r_cnt;
    w_hi_nxt     = r_hi;
    w_lo_nxt     = r_lo;
`ifdef MULT_SEQ_OVF_EN
    w_signed_nxt = r_signed;
    w_ovf_nxt    = r_ovf;
`endif
    w_prod = (r_sign_a ^ r_sign_b) ? (~r_acc + AW'(1)) : r_acc;

    case (r_state)
      ST_IDLE: begin
        if (START) begin
          w_sign_a_nxt = A[WIDTH-1] & SIGNED;
          w_sign_b_nxt = B[WIDTH-1] & SIGNED;
          w_mag_a_nxt  = (A[WIDTH-1] & SIGNED) ? (~A + WIDTH'(1)) : A;
          w_mplr_nxt   = (B[WIDTH-1] & SIGNED) ? (~B + WIDTH'(1)) : B;
          w_acc_nxt    = '0;
          w_cnt_nxt    = '0;
          w_state_nxt  = ST_CALC;
`ifdef MULT_SEQ_OVF_EN
          w_signed_nxt = SIGNED;
`endif
        end
      end
      ST_CALC: begin
        // Slice sum (with carry) lands on top; shift retires STEP low bits.
        w_acc_nxt  = AW'({w_sum, r_acc[WIDTH-1:0]} >> STEP);
        w_mplr_nxt = r_mplr >> STEP;
        w_cnt_nxt  = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(N - 1)) begin
          w_state_nxt = ST_FIX;
        end
      end
      ST_FIX: begin
        w_hi_nxt    = w_prod[AW-1:WIDTH];
        w_lo_nxt    = w_prod[WIDTH-1:0];
        w_done_nxt  = 1'b1;
        w_state_nxt = ST_IDLE;
`ifdef MULT_SEQ_OVF_EN
        w_ovf_nxt = r_signed ? (w_prod[AW-1:WIDTH] != {WIDTH{w_prod[WIDTH-1]}})
                             : (w_prod[AW-1:WIDTH] != '0);
`endif
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_ready_nxt = (w_state_nxt == ST_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state  <= ST_IDLE;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_mag_a  <= '0;
      r_mplr   <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
`ifdef MULT_SEQ_OVF_EN
      r_signed <= 1'b0;
      r_ovf    <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_ready  <= w_ready_nxt;
      r_done   <= w_done_nxt;
      r_sign_a <= w_sign_a_nxt;
      r_sign_b <= w_sign_b_nxt;
      r_mag_a  <= w_mag_a_nxt;
      r_mplr   <= w_mplr_nxt;
      r_acc    <= w_acc_nxt;
      r_cnt    <= w_cnt_nxt;
      r_hi     <= w_hi_nxt;
      r_lo     <= w_lo_nxt;
`ifdef MULT_SEQ_OVF_EN
      r_signed <= w_signed_nxt;
      r_ovf    <= w_ovf_nxt;
`endif
    end
  end

  assign READY = r_ready;
  assign DONE  = r_done;
  assign HI    = r_hi;
  assign LO    = r_lo;
`ifdef MULT_SEQ_OVF_EN
  assign OVF   = r_ovf;
`endif

endmodule

// File: tb/tb_mult_seq_param.sv
// Bench for mult_seq_param: STEP=1 and STEP=4 instances checked against a
// plain 64-bit arithmetic product model; OVF checked when MULT_SEQ_OVF_EN is set.
module tb_mult_seq_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start1, start4;
  logic        sgn;
  logic [31:0] a, b;
  logic        ready1, done1, ready4, done4;
  logic [31:0] hi1, lo1, hi4, lo4;
  logic        sel;
`ifdef MULT_SEQ_OVF_EN
  logic        ovf1, ovf4;
  wire         ovf_s = sel ? ovf4 : ovf1;
`endif

  wire        ready_s = sel ? ready4 : ready1;
  wire        done_s  = sel ? done4  : done1;
  wire [31:0] hi_s    = sel ? hi4    : hi1;
  wire [31:0] lo_s    = sel ? lo4    : lo1;

  always #5 clk = ~clk;

  mult_seq_param #(.WIDTH(32), .STEP(1)) dut1 (
    .CLK (clk), .RST (rst_n), .START (start1), .SIGNED (sgn),
    .A (a), .B (b), .READY (ready1), .DONE (done1), .HI (hi1), .LO (lo1)
`ifdef MULT_SEQ_OVF_EN
    , .OVF (ovf1)
`endif
  );

  mult_seq_param #(.WIDTH(32), .STEP(4)) dut4 (
    .CLK (clk), .RST (rst_n), .START (start4), .SIGNED (sgn),
    .A (a), .B (b), .READY (ready4), .DONE (done4), .HI (hi4), .LO (lo4)
`ifdef MULT_SEQ_OVF_EN
    , .OVF (ovf4)
`endif
  );

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [63:0] last [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y, input logic s);
    longint          sx, sy;
    longint unsigned ux, uy;
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    ux = 64'(x);
    uy = 64'(y);
    return ux * uy;
  endfunction

  function automatic logic ref_ovf(input logic [31:0] x, input logic [31:0] y, input logic s);
    longint          p;
    longint unsigned u;
    if (s) begin
      p = longint'($signed(x)) * longint'($signed(y));
      return (p > 64'sd2147483647) || (p < -64'sd2147483648);
    end
    u = 64'(x) * 64'(y);
    return u > 64'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic set_start(input logic v);
    if (sel) start4 = v;
    else     start1 = v;
  endtask

  // mode 0: plain op; 1: extra START during CALC; 2: reset at CALC cycle 10.
  task automatic run_op(input logic s4, input logic [31:0] xa, input logic [31:0] xb,
                        input logic xs, input int mode, input bit stop_at_done);
    int          n, lat, lat_done, ndone;
    logic [63:0] exp;
    sel      = s4;
    n        = s4 ? 8 : 32;
    exp      = ref_prod(xa, xb, xs);
    a        = xa;
    b        = xb;
    sgn      = xs;
    set_start(1'b1);
    @(posedge clk); #1;
    set_start(1'b0);
    check("ready_busy", 64'(ready_s), 64'(1'b0));
    a   = $urandom;
    b   = $urandom;
    sgn = 1'($urandom_range(0, 1));
    lat = 0; lat_done = -1; ndone = 0;
    while (lat < n + 3) begin
      @(posedge clk); #1;
      lat++;
      if (mode == 2 && lat == 11) begin
        check("rst_ready", 64'(ready_s), 64'(1'b1));
        check("rst_hilo", {hi_s, lo_s}, 64'h0);
        check("rst_done", 64'(done_s), 64'(1'b0));
        rst_n   = 1'b1;
        last[0] = '0;
        last[1] = '0;
        @(posedge clk); #1;
        check("rst_no_done", 64'(done_s), 64'(1'b0));
        return;
      end
      if (mode == 2 && lat == 10) rst_n = 1'b0;
      if (done_s) begin
        ndone++;
        if (lat_done < 0) lat_done = lat;
        if (stop_at_done) break;
      end
      if (lat == 3) check("hold_calc", {hi_s, lo_s}, last[sel]);
      if (mode == 1 && lat == 5) begin
        check("ready_calc", 64'(ready_s), 64'(1'b0));
        a   = 32'd9;
        b   = 32'd9;
        sgn = ~xs;
        set_start(1'b1);
      end
      if (mode == 1 && lat == 6) set_start(1'b0);
    end
    check("latency", 64'(lat_done), 64'(n + 1));
    if (!stop_at_done) check("done_pulses", 64'(ndone), 64'(1));
    check("product", {hi_s, lo_s}, exp);
`ifdef MULT_SEQ_OVF_EN
    check("ovf", 64'(ovf_s), 64'(ref_ovf(xa, xb, xs)));
`endif
    last[sel] = exp;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start1 = 1'b0; start4 = 1'b0; sgn = 1'b0;
    a = '0; b = '0; sel = 1'b0;
    last[0] = '0; last[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready1", 64'(ready1), 64'(1'b1));
    check("reset_done1", 64'(done1), 64'(1'b0));
    check("reset_hilo1", {hi1, lo1}, 64'h0);
    check("reset_ready4", 64'(ready4), 64'(1'b1));
    check("reset_hilo4", {hi4, lo4}, 64'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
    check("max_unsigned", {hi1, lo1}, 64'hFFFF_FFFE_0000_0001);
    run_op(1'b0, 32'hFFFF_FFFD, 32'd5, 1'b1, 0, 1'b0);
    check("neg3x5_signed", {hi1, lo1}, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op(1'b0, 32'hFFFF_FFFD, 32'd5, 1'b0, 0, 1'b0);
    check("neg3x5_unsigned", {hi1, lo1}, 64'h0000_0004_FFFF_FFF1);
    run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 1'b0);
    run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b1, 0, 1'b0);
    run_op(1'b0, 32'h0000_0000, 32'hFFFF_FFFB, 1'b1, 0, 1'b0);
    run_op(1'b0, 32'd7, 32'd6, 1'b0, 1, 1'b0);
    check("ignored_start", {hi1, lo1}, 64'd42);
    run_op(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 2, 1'b0);
    run_op(1'b0, 32'd2, 32'd3, 1'b0, 0, 1'b0);
    check("after_abort", {hi1, lo1}, 64'd6);

    run_op(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFA, 1'b1, 0, 1'b1);
    run_op(1'b1, 32'd1, 32'd1, 1'b0, 0, 1'b0);
    check("b2b_step4", {hi4, lo4}, 64'd1);
    run_op(1'b0, 32'hDEAD_BEEF, 32'h0000_0003, 1'b1, 0, 1'b1);
    run_op(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      run_op(1'($urandom_range(0, 1)), pick(), pick(), 1'($urandom_range(0, 1)), 0,
             1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
